// File: rtl/ram64_pkg.sv
// ram64_pkg: depth, pointer and count types shared by the 64-entry distributed-RAM FIFO.
package ram64_pkg;
    localparam int FIFO_DEPTH = 64;
    localparam int PTR_W      = 6;
    localparam int COUNT_W    = 7;
    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [COUNT_W-1:0] count_t;
endpackage

// File: rtl/ram64_fifo_if.sv
// ram64_fifo_if: push/pop handshake and status bundle of ram64_fifo.
interface ram64_fifo_if import ram64_pkg::*; #(parameter int WIDTH = 8);
    logic             WE;
    logic [WIDTH-1:0] DIN;
    logic             RE;
    logic [WIDTH-1:0] DOUT;
    logic             DVALID;
    logic             FULL;
    logic             EMPTY;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    count_t           COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;
    modport master (output WE, DIN, RE,
                    input  DOUT, DVALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW);
    modport slave  (input  WE, DIN, RE,
                    output DOUT, DVALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW);
endinterface

// File: rtl/ram64_fifo_ram.sv
// ram64_fifo_ram: WIDTH-bit storage built from one RAM64X1D per bit, written at
// the write pointer and read asynchronously at the read pointer.
module ram64_fifo_ram import ram64_pkg::*; #(parameter int WIDTH = 8) (
    input  logic             WCLK,
    input  logic             we,
    input  ptr_t             wr_ptr,
    input  ptr_t             rd_ptr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dpo
);
    logic [WIDTH-1:0] spo_unused;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        RAM64X1D #(.INIT(64'h0), .IS_WCLK_INVERTED(1'b0)) u_ram (
            .DPO(dpo[i]), .SPO(spo_unused[i]),
            .A0(wr_ptr[0]), .A1(wr_ptr[1]), .A2(wr_ptr[2]),
            .A3(wr_ptr[3]), .A4(wr_ptr[4]), .A5(wr_ptr[5]),
            .D(din[i]),
            .DPRA0(rd_ptr[0]), .DPRA1(rd_ptr[1]), .DPRA2(rd_ptr[2]),
            .DPRA3(rd_ptr[3]), .DPRA4(rd_ptr[4]), .DPRA5(rd_ptr[5]),
            .WCLK(WCLK), .WE(we)
        );
    end
endmodule

// File: rtl/ram64x1d.sv
// RAM64X1D: simulation model of the Xilinx 64x1 dual-port distributed RAM primitive.
module RAM64X1D #(
    parameter logic [63:0] INIT             = 64'h0,
    parameter logic        IS_WCLK_INVERTED = 1'b0
) (
    output logic DPO,
    output logic SPO,
    input  logic A0, A1, A2, A3, A4, A5,
    input  logic D,
    input  logic DPRA0, DPRA1, DPRA2, DPRA3, DPRA4, DPRA5,
    input  logic WCLK,
    input  logic WE
);
    logic [63:0] mem = INIT;
    logic        wclk;
    logic [5:0]  a;
    logic [5:0]  dpra;
    assign wclk = WCLK ^ IS_WCLK_INVERTED;
    assign a    = {A5, A4, A3, A2, A1, A0};
    assign dpra = {DPRA5, DPRA4, DPRA3, DPRA2, DPRA1, DPRA0};
    assign SPO  = mem[a];
    assign DPO  = mem[dpra];
    always_ff @(posedge wclk)
        if (WE) mem[a] <= D;
endmodule

// File: rtl/ram64_fifo.sv
// ram64_fifo: 64-entry FIFO on distributed RAM with registered pop data,
// occupancy count, almost-full/empty thresholds and overflow/underflow pulses.
module ram64_fifo import ram64_pkg::*; #(
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 8
) (
    input logic         CLK,
    input logic         RST_N,
    ram64_fifo_if.slave bus
);
    ptr_t             wr_ptr, rd_ptr;
    count_t           count, count_nx;
    logic [WIDTH-1:0] dout, rd_data;
    logic             dvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic             push, pop;
    // Acceptance uses the registered flags, so at 0 or 64 one side is always refused.
    assign push     = bus.WE && !full;
    assign pop      = bus.RE && !empty;
    assign count_nx = count + count_t'(push) - count_t'(pop);
    ram64_fifo_ram #(.WIDTH(WIDTH)) u_ram (
        .WCLK(CLK), .we(push && RST_N), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
        .din(bus.DIN), .dpo(rd_data)
    );
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dout         <= '0;
            dvalid       <= 1'b0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr + ptr_t'(push);
            rd_ptr       <= rd_ptr + ptr_t'(pop);
            count        <= count_nx;
            dvalid       <= pop;
            if (pop) dout <= rd_data;
            full         <= count_nx == count_t'(FIFO_DEPTH);
            empty        <= count_nx == '0;
            almost_full  <= count_nx >= count_t'(AF_LEVEL);
            almost_empty <= count_nx <= count_t'(AE_LEVEL);
            overflow     <= bus.WE && full;
            underflow    <= bus.RE && empty;
        end
    end
    assign bus.DOUT         = dout;
    assign bus.DVALID       = dvalid;
    assign bus.FULL         = full;
    assign bus.EMPTY        = empty;
    assign bus.ALMOST_FULL  = almost_full;
    assign bus.ALMOST_EMPTY = almost_empty;
    assign bus.COUNT        = count;
    assign bus.OVERFLOW     = overflow;
    assign bus.UNDERFLOW    = underflow;
endmodule

// File: tb/tb_ram64_fifo.sv
// tb_ram64_fifo: directed vector table plus hand-written fill/drain, wrap,
// simultaneous push/pop and mid-stream reset sequences for ram64_fifo.
module tb_ram64_fifo;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ram64_fifo_if #(.WIDTH(8)) b ();
    ram64_fifo #(.WIDTH(8), .AF_LEVEL(56), .AE_LEVEL(8)) dut (.CLK(CLK), .RST_N(RST_N), .bus(b));
    always #5 CLK = ~CLK;
    // flag order: {dvalid, full, empty, almost_full, almost_empty, overflow, underflow}
    logic [21:0] obs;
    assign obs = {b.COUNT, b.DOUT, b.DVALID, b.FULL, b.EMPTY, b.ALMOST_FULL,
                  b.ALMOST_EMPTY, b.OVERFLOW, b.UNDERFLOW};
    typedef struct {
        logic       we, re;
        logic [7:0] din;
        logic [6:0] cnt;
        logic [7:0] dout;
        logic [6:0] fl;
    } vec_t;
    vec_t vecs[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step(input logic we, input logic re, input logic [7:0] din);
        b.WE = we; b.RE = re; b.DIN = din;
        @(posedge CLK);
        #1;
    endtask
    initial begin
        vecs[0]  = '{0, 0, 8'h00, 7'd0, 8'h00, 7'b0010100};
        vecs[1]  = '{1, 1, 8'h11, 7'd1, 8'h00, 7'b0000101};
        vecs[2]  = '{0, 1, 8'h00, 7'd0, 8'h11, 7'b1010100};
        vecs[3]  = '{0, 1, 8'h00, 7'd0, 8'h11, 7'b0010101};
        vecs[4]  = '{0, 1, 8'h00, 7'd0, 8'h11, 7'b0010101};
        vecs[5]  = '{0, 1, 8'h00, 7'd0, 8'h11, 7'b0010101};
        vecs[6]  = '{1, 0, 8'h22, 7'd1, 8'h11, 7'b0000100};
        vecs[7]  = '{1, 0, 8'h33, 7'd2, 8'h11, 7'b0000100};
        vecs[8]  = '{1, 1, 8'h44, 7'd2, 8'h22, 7'b1000100};
        vecs[9]  = '{0, 1, 8'h00, 7'd1, 8'h33, 7'b1000100};
        vecs[10] = '{0, 1, 8'h00, 7'd0, 8'h44, 7'b1010100};
        vecs[11] = '{0, 0, 8'h00, 7'd0, 8'h44, 7'b0010100};
        b.WE = 0; b.RE = 0; b.DIN = '0;
        #12;
        chk("reset_state", 32'(obs), 32'({7'd0, 8'h00, 7'b0010100}));
        @(negedge CLK) RST_N = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].din);
            chk($sformatf("vec%0d", i), 32'(obs), 32'({vecs[i].cnt, vecs[i].dout, vecs[i].fl}));
        end
        // fill to 64, watching the thresholds
        for (int i = 0; i < 64; i++) begin
            step(1, 0, 8'(i));
            chk($sformatf("fill%0d_count", i), 32'(b.COUNT), 32'(i + 1));
            chk($sformatf("fill%0d_flags", i), 32'({b.FULL, b.EMPTY, b.ALMOST_FULL, b.ALMOST_EMPTY}),
                32'({i + 1 == 64, 1'b0, i + 1 >= 56, i + 1 <= 8}));
        end
        step(1, 0, 8'hFF);
        chk("ovf_pulse", 32'({b.OVERFLOW, b.FULL, b.COUNT}), 32'({1'b1, 1'b1, 7'd64}));
        step(0, 0, 8'h00);
        chk("ovf_clear", 32'({b.OVERFLOW, b.COUNT}), 32'({1'b0, 7'd64}));
        step(1, 1, 8'hEE);
        chk("full_wr_rd", 32'({b.COUNT, b.OVERFLOW, b.DVALID, b.DOUT, b.FULL}),
            32'({7'd63, 1'b1, 1'b1, 8'h00, 1'b0}));
        for (int i = 1; i < 64; i++) begin
            step(0, 1, 8'h00);
            chk($sformatf("drain%0d", i), 32'({b.DVALID, b.DOUT}), 32'({1'b1, 8'(i)}));
        end
        chk("drained", 32'({b.EMPTY, b.COUNT, b.ALMOST_FULL}), 32'({1'b1, 7'd0, 1'b0}));
        // move both pointers to 44 so the next 24 words cross 63 -> 0
        for (int i = 0; i < 40; i++) step(1, 0, 8'(i));
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 8'h00);
            chk($sformatf("p40_%0d", i), 32'(b.DOUT), 32'(i));
        end
        for (int i = 0; i < 24; i++) step(1, 0, 8'hA0 + 8'(i));
        chk("wrap_count", 32'(b.COUNT), 32'd24);
        for (int i = 0; i < 24; i++) begin
            step(0, 1, 8'h00);
            chk($sformatf("wrap%0d", i), 32'({b.DVALID, b.DOUT}), 32'({1'b1, 8'hA0 + 8'(i)}));
        end
        chk("wrap_empty", 32'({b.COUNT, b.EMPTY}), 32'({7'd0, 1'b1}));
        for (int i = 0; i < 10; i++) step(1, 0, 8'h60 + 8'(i));
        step(1, 1, 8'h70);
        chk("mid_wr_rd", 32'({b.COUNT, b.DOUT, b.DVALID, b.OVERFLOW, b.UNDERFLOW}),
            32'({7'd10, 8'h60, 1'b1, 1'b0, 1'b0}));
        for (int i = 1; i < 11; i++) begin
            step(0, 1, 8'h00);
            chk($sformatf("mid_pop%0d", i), 32'(b.DOUT), i == 10 ? 32'h70 : 32'(8'h60 + 8'(i)));
        end
        chk("mid_empty", 32'(b.COUNT), 32'd0);
        // asynchronous reset between edges with 20 words stored
        for (int i = 0; i < 21; i++) step(1, 0, 8'h80 + 8'(i));
        step(0, 1, 8'h00);
        chk("pre_reset", 32'({b.COUNT, b.DOUT, b.DVALID}), 32'({7'd20, 8'h80, 1'b1}));
        b.RE = 0;
        #3 RST_N = 1'b0;
        #1 chk("async_reset", 32'(obs), 32'({7'd0, 8'h00, 7'b0010100}));
        #2 RST_N = 1'b1;
        step(1, 0, 8'h5A);
        chk("post_push", 32'({b.COUNT, b.EMPTY}), 32'({7'd1, 1'b0}));
        step(0, 1, 8'h00);
        chk("post_pop", 32'({b.COUNT, b.DOUT, b.DVALID}), 32'({7'd0, 8'h5A, 1'b1}));
        step(0, 1, 8'h00);
        chk("no_stale", 32'({b.COUNT, b.DOUT, b.DVALID, b.UNDERFLOW}), 32'({7'd0, 8'h5A, 1'b0, 1'b1}));
        step(0, 0, 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
